// File: rtl/rv64g_instr_dispatcher.sv
// Dispatcher: 2-entry buffer of launched instructions, head routed to one of NU credit-limited units.
// Latency: 1 cycle from push into an empty buffer to dispatch; lock_set_o is combinational in the fire cycle.
// Backpressure: instr_ready_o = buffer not full (registered state only); unit valid held until ready.
module rv64g_instr_dispatcher #(
    parameter int DW      = 64,
    parameter int NR      = 64,
    parameter int NU      = 4,
    parameter int MAX_OUT = 2,
    localparam int UW     = (NU > 1) ? $clog2(NU) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic [DW-1:0] instr_i,
    input  logic [UW-1:0] instr_unit_i,
    input  logic [NR-1:0] instr_rd_mask_i,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    output logic [DW-1:0] unit_instr_o,
    output logic [NU-1:0] unit_valid_o,
    input  logic [NU-1:0] unit_ready_i,
    input  logic [NU-1:0] unit_done_i,
    output logic [NR-1:0] lock_set_o,
    output logic          illegal_o
);
    localparam logic [2:0]  MAX_C = 3'(MAX_OUT);
    localparam logic [UW:0] NU_C  = (UW+1)'(NU);

    logic [DW-1:0] instr_q [2];
    logic [DW-1:0] instr_d [2];
    logic [UW-1:0] unit_q  [2];
    logic [UW-1:0] unit_d  [2];
    logic [NR-1:0] mask_q  [2];
    logic [NR-1:0] mask_d  [2];
    logic          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [2:0]    credit_q [NU];
    logic [2:0]    credit_d [NU];

    logic [DW-1:0] head_instr;
    logic [UW-1:0] head_unit;
    logic [NR-1:0] head_mask;
    logic          not_empty, head_legal, illegal, fire, push, pop;
    logic [NU-1:0] valid_vec, fire_vec, dec_vec;

    always_comb begin
        head_instr = instr_q[rptr_q];
        head_unit  = unit_q[rptr_q];
        head_mask  = mask_q[rptr_q];
        not_empty  = (cnt_q != 2'd0);
        head_legal = ({1'b0, head_unit} < NU_C);
        illegal    = not_empty && !head_legal;
    end

    // Valid is independent of ready so the offer stays stable until the unit takes it.
    always_comb begin
        valid_vec = '0;
        fire_vec  = '0;
        for (int u = 0; u < NU; u++) begin
            if (not_empty && (head_unit == UW'(u)) && (credit_q[u] < MAX_C)) begin
                valid_vec[u] = 1'b1;
                fire_vec[u]  = unit_ready_i[u];
            end
        end
        fire = |fire_vec;
    end

    always_comb begin
        push    = instr_valid_i && (cnt_q != 2'd2) && !clear_i;
        pop     = fire || illegal;
        instr_d = instr_q;
        unit_d  = unit_q;
        mask_d  = mask_q;
        if (push) begin
            instr_d[wptr_q] = instr_i;
            unit_d[wptr_q]  = instr_unit_i;
            mask_d[wptr_q]  = instr_rd_mask_i;
        end
        wptr_d = wptr_q ^ push;
        rptr_d = rptr_q ^ pop;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            wptr_d = 1'b0;
            rptr_d = 1'b0;
            cnt_d  = 2'd0;
        end
    end

    // Credits survive a flush: in-flight instructions still report completion.
    always_comb begin
        dec_vec  = '0;
        credit_d = credit_q;
        for (int u = 0; u < NU; u++) begin
            dec_vec[u] = unit_done_i[u] && (credit_q[u] != 3'd0);
            if (fire_vec[u] && !dec_vec[u]) begin
                credit_d[u] = credit_q[u] + 3'd1;
            end else if (dec_vec[u] && !fire_vec[u]) begin
                credit_d[u] = credit_q[u] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q  <= '{default: '0};
            unit_q   <= '{default: '0};
            mask_q   <= '{default: '0};
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
            credit_q <= '{default: '0};
        end else begin
            instr_q  <= instr_d;
            unit_q   <= unit_d;
            mask_q   <= mask_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
        end
    end

    assign instr_ready_o = (cnt_q != 2'd2);
    assign unit_valid_o  = valid_vec;
    assign unit_instr_o  = not_empty ? head_instr : '0;
    assign lock_set_o    = fire ? head_mask : '0;
    assign illegal_o     = illegal;

endmodule
